writeline_avalon_burst: RTL and testbench

//  Downstream stage of the writeline link. Takes one 128-bit cache line write request
//  (address, line) and issues it to Avalon-MM as a 4-beat, 32-bit burst write.
//  It acknowledges completion with a one-cycle done pulse back to the link.

---
 rtl/writeline_avalon_burst.sv | 134 +++++++++++++
 tb/tb_writeline_avalon_burst.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeline_avalon_burst.sv
// Writeline link downstream stage: turns one 128-bit line write into a 4-beat
// 32-bit Avalon-MM burst, then pulses done and holds off new requests for a guard interval.
module writeline_avalon_burst #(
    parameter int DONE_GAP = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         writeline_do,
    output logic         writeline_done,
    input  logic [31:0]  writeline_address,
    input  logic [127:0] writeline_line,
    output logic [29:0]  avm_address,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    output logic [3:0]   avm_byteenable,
    output logic [2:0]   avm_burstcount,
    input  logic         avm_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [2:0] GAP_INIT = 3'(DONE_GAP);

    state_t         state_r, state_nxt_s;
    logic [1:0]     beat_r, beat_nxt_s;
    logic [2:0]     gap_cnt_r, gap_nxt_s;
    logic [127:0]   line_r, line_nxt_s;
    logic [29:0]    avm_address_r, addr_nxt_s;
    logic           avm_write_r, write_nxt_s;
    logic [31:0]    avm_writedata_r, wdata_nxt_s;
    logic           done_r, done_nxt_s;

    // Line-offset bits never reach the bus; the burst always covers a whole aligned line.
    logic           unused_addr_s;
    assign unused_addr_s = ^writeline_address[3:0];

    function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] idx);
        case (idx)
            2'd0:    word_sel = line[31:0];
            2'd1:    word_sel = line[63:32];
            2'd2:    word_sel = line[95:64];
            2'd3:    word_sel = line[127:96];
            default: word_sel = 32'h0000_0000;
        endcase
    endfunction

    // Next-state and next-output computation; every Avalon output is registered.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        gap_nxt_s   = gap_cnt_r;
        line_nxt_s  = line_r;
        addr_nxt_s  = avm_address_r;
        write_nxt_s = avm_write_r;
        wdata_nxt_s = avm_writedata_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (writeline_do) begin
                    line_nxt_s  = writeline_line;
                    addr_nxt_s  = {writeline_address[31:4], 2'b00};
                    beat_nxt_s  = 2'd0;
                    write_nxt_s = 1'b1;
                    wdata_nxt_s = writeline_line[31:0];
                    state_nxt_s = ST_WRITE;
                end else begin
                    write_nxt_s = 1'b0;
                end
            end
            ST_WRITE: begin
                if (avm_write_r && !avm_waitrequest) begin
                    if (beat_r == 2'd3) begin
                        write_nxt_s = 1'b0;
                        done_nxt_s  = 1'b1;
                        gap_nxt_s   = GAP_INIT;
                        state_nxt_s = ST_GAP;
                    end else begin
                        beat_nxt_s  = beat_r + 2'd1;
                        wdata_nxt_s = word_sel(line_r, beat_r + 2'd1);
                    end
                end else begin
                    write_nxt_s = 1'b1;
                end
            end
            ST_GAP: begin
                // The link keeps do high until its delayed done arrives, so do is ignored here.
                if (gap_cnt_r == 3'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_nxt_s = gap_cnt_r - 3'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                write_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            beat_r          <= 2'd0;
            gap_cnt_r       <= 3'd0;
            line_r          <= 128'd0;
            avm_address_r   <= 30'd0;
            avm_write_r     <= 1'b0;
            avm_writedata_r <= 32'd0;
            done_r          <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            beat_r          <= beat_nxt_s;
            gap_cnt_r       <= gap_nxt_s;
            line_r          <= line_nxt_s;
            avm_address_r   <= addr_nxt_s;
            avm_write_r     <= write_nxt_s;
            avm_writedata_r <= wdata_nxt_s;
            done_r          <= done_nxt_s;
        end
    end

    assign writeline_done = done_r;
    assign avm_address    = avm_address_r;
    assign avm_write      = avm_write_r;
    assign avm_writedata  = avm_writedata_r;
    assign avm_byteenable = 4'hF;
    assign avm_burstcount = 3'd4;

endmodule

// File: tb/tb_writeline_avalon_burst.sv
// Directed self-checking bench for writeline_avalon_burst: latency, stalls, guard gap,
// input churn, mid-burst reset and constant burst attributes.
module tb_writeline_avalon_burst;

    logic         clk;
    logic         rst;
    logic         writeline_do;
    logic         writeline_done;
    logic [31:0]  writeline_address;
    logic [127:0] writeline_line;
    logic [29:0]  avm_address;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic [3:0]   avm_byteenable;
    logic [2:0]   avm_burstcount;
    logic         avm_waitrequest;

    int tests = 0;
    int fails = 0;

    // Observation results filled by observe()
    int          obs_done, obs_acc, obs_bad, obs_unstable, obs_starts;
    int          obs_done_t[4];
    int          obs_start_t[4];
    logic [31:0] obs_beat[8];
    logic [29:0] exp_addr;

    writeline_avalon_burst #(.DONE_GAP(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .writeline_do      (writeline_do),
        .writeline_done    (writeline_done),
        .writeline_address (writeline_address),
        .writeline_line    (writeline_line),
        .avm_address       (avm_address),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs ncyc cycles; cycle t is the one after the t-th edge from the call.
    // wr_pat[t] is waitrequest in cycle t; do drops from cycle do_drop on.
    task automatic observe(input int ncyc, input logic [31:0] wr_pat, input int do_drop, input bit churn);
        logic        pw, pwait;
        logic [31:0] pdata;
        logic [29:0] paddr;
        obs_done = 0; obs_acc = 0; obs_bad = 0; obs_unstable = 0; obs_starts = 0;
        for (int i = 0; i < 4; i++) begin obs_done_t[i] = 0; obs_start_t[i] = 0; end
        for (int i = 0; i < 8; i++) obs_beat[i] = 32'h0;
        pw = 1'b0; pwait = 1'b0; pdata = 32'h0; paddr = 30'h0;
        for (int t = 1; t <= ncyc; t++) begin
            @(posedge clk); #1;
            avm_waitrequest = wr_pat[t];
            if (writeline_done) begin
                if (obs_done < 4) obs_done_t[obs_done] = t;
                obs_done++;
            end
            if (avm_write) begin
                if (!pw) begin
                    if (obs_starts < 4) obs_start_t[obs_starts] = t;
                    obs_starts++;
                end
                if (avm_byteenable !== 4'hF || avm_burstcount !== 3'd4 ||
                    avm_address[1:0] !== 2'b00 || avm_address !== exp_addr) obs_bad++;
                if (pw && pwait && (avm_writedata !== pdata || avm_address !== paddr)) obs_unstable++;
                if (!avm_waitrequest) begin
                    if (obs_acc < 8) obs_beat[obs_acc] = avm_writedata;
                    obs_acc++;
                end
            end
            pw = avm_write; pwait = avm_waitrequest; pdata = avm_writedata; paddr = avm_address;
            if (t == do_drop) writeline_do = 1'b0;
            if (churn && t == 2) begin
                writeline_line    = {4{32'hDEAD_BEEF}};
                writeline_address = 32'hFFFF_FFF0;
            end
        end
        avm_waitrequest = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; writeline_do = 1'b0; writeline_address = 32'h0;
        writeline_line = 128'h0; avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (writeline_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", writeline_done); end
        tests++; if (avm_write !== 1'b0) begin fails++; $display("FAIL reset_write: got %0b expected 0", avm_write); end
        tests++; if (avm_address !== 30'h0) begin fails++; $display("FAIL reset_address: got %0h expected 0", avm_address); end
        tests++; if (avm_writedata !== 32'h0) begin fails++; $display("FAIL reset_writedata: got %0h expected 0", avm_writedata); end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (avm_write !== 1'b0) begin fails++; $display("FAIL idle_write: got %0b expected 0", avm_write); end
    endtask

    task automatic test_no_stall;
        logic [127:0] ln;
        ln = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        writeline_line = ln; writeline_address = 32'h0001_2348; exp_addr = 30'h0000_48D0;
        writeline_do = 1'b1;
        observe(10, 32'h0, 5, 1'b0);
        tests++; if (obs_start_t[0] !== 1) begin fails++; $display("FAIL nostall_first_beat: got cycle %0d expected 1", obs_start_t[0]); end
        tests++; if (obs_done !== 1) begin fails++; $display("FAIL nostall_done_count: got %0d expected 1", obs_done); end
        tests++; if (obs_done_t[0] !== 5) begin fails++; $display("FAIL nostall_done_cycle: got %0d expected 5", obs_done_t[0]); end
        tests++; if (obs_acc !== 4) begin fails++; $display("FAIL nostall_accepts: got %0d expected 4", obs_acc); end
        tests++; if (obs_bad !== 0) begin fails++; $display("FAIL nostall_attr: got %0d bad cycles expected 0", obs_bad); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs_beat[k] !== ln[32*k +: 32]) begin
                fails++; $display("FAIL nostall_beat%0d: got %08h expected %08h", k, obs_beat[k], ln[32*k +: 32]);
            end
        end
    endtask

    task automatic test_stalls;
        logic [127:0] ln;
        ln = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        writeline_line = ln; writeline_address = 32'h8000_00FC; exp_addr = 30'h2000_003C;
        writeline_do = 1'b1;
        observe(14, 32'h0000_019C, 10, 1'b0);
        tests++; if (obs_acc !== 4) begin fails++; $display("FAIL stall_accepts: got %0d expected 4", obs_acc); end
        tests++; if (obs_done !== 1) begin fails++; $display("FAIL stall_done_count: got %0d expected 1", obs_done); end
        tests++; if (obs_done_t[0] !== 10) begin fails++; $display("FAIL stall_done_cycle: got %0d expected 10", obs_done_t[0]); end
        tests++; if (obs_unstable !== 0) begin fails++; $display("FAIL stall_stability: got %0d changes expected 0", obs_unstable); end
        tests++; if (obs_starts !== 1) begin fails++; $display("FAIL stall_write_gaps: got %0d write starts expected 1", obs_starts); end
        tests++; if (obs_bad !== 0) begin fails++; $display("FAIL stall_attr: got %0d bad cycles expected 0", obs_bad); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs_beat[k] !== ln[32*k +: 32]) begin
                fails++; $display("FAIL stall_beat%0d: got %08h expected %08h", k, obs_beat[k], ln[32*k +: 32]);
            end
        end
    endtask

    task automatic test_guard;
        logic [127:0] ln;
        ln = {32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F};
        writeline_line = ln; writeline_address = 32'h0000_1000; exp_addr = 30'h0000_0400;
        // do held through done and the two following cycles, then dropped
        writeline_do = 1'b1;
        observe(16, 32'h0, 8, 1'b0);
        tests++; if (obs_starts !== 1) begin fails++; $display("FAIL guard_held_starts: got %0d expected 1", obs_starts); end
        tests++; if (obs_acc !== 4) begin fails++; $display("FAIL guard_held_accepts: got %0d expected 4", obs_acc); end
        tests++; if (obs_done !== 1) begin fails++; $display("FAIL guard_held_done: got %0d expected 1", obs_done); end
        // do still high in the third cycle after done starts a new burst
        writeline_do = 1'b1;
        observe(18, 32'h0, 13, 1'b0);
        tests++; if (obs_starts !== 2) begin fails++; $display("FAIL guard_b2b_starts: got %0d expected 2", obs_starts); end
        tests++; if (obs_start_t[1] !== 9) begin fails++; $display("FAIL guard_b2b_start_cycle: got %0d expected 9", obs_start_t[1]); end
        tests++; if (obs_done !== 2) begin fails++; $display("FAIL guard_b2b_done: got %0d expected 2", obs_done); end
        tests++; if (obs_done_t[1] !== 13) begin fails++; $display("FAIL guard_b2b_done_cycle: got %0d expected 13", obs_done_t[1]); end
        tests++; if (obs_acc !== 8) begin fails++; $display("FAIL guard_b2b_accepts: got %0d expected 8", obs_acc); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs_beat[k + 4] !== ln[32*k +: 32]) begin
                fails++; $display("FAIL guard_b2b_beat%0d: got %08h expected %08h", k, obs_beat[k + 4], ln[32*k +: 32]);
            end
        end
    endtask

    task automatic test_churn;
        logic [127:0] ln;
        ln = {32'hA5A5_0004, 32'h5A5A_0003, 32'hA5A5_0002, 32'h5A5A_0001};
        writeline_line = ln; writeline_address = 32'h0ABC_DEF0; exp_addr = 30'h02AF_37BC;
        writeline_do = 1'b1;
        observe(10, 32'h0, 5, 1'b1);
        tests++; if (obs_bad !== 0) begin fails++; $display("FAIL churn_address: got %0d bad cycles expected 0", obs_bad); end
        tests++; if (obs_done_t[0] !== 5) begin fails++; $display("FAIL churn_done_cycle: got %0d expected 5", obs_done_t[0]); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs_beat[k] !== ln[32*k +: 32]) begin
                fails++; $display("FAIL churn_beat%0d: got %08h expected %08h", k, obs_beat[k], ln[32*k +: 32]);
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [127:0] ln;
        int nd, nw;
        writeline_line = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
        writeline_address = 32'h0000_0040; exp_addr = 30'h0000_0010;
        writeline_do = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (avm_write !== 1'b1) begin fails++; $display("FAIL midrst_pre_write: got %0b expected 1", avm_write); end
        rst = 1'b1; writeline_do = 1'b0;
        @(posedge clk); #1;
        tests++; if (avm_write !== 1'b0) begin fails++; $display("FAIL midrst_write: got %0b expected 0", avm_write); end
        tests++; if (writeline_done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %0b expected 0", writeline_done); end
        tests++; if (avm_address !== 30'h0) begin fails++; $display("FAIL midrst_address: got %0h expected 0", avm_address); end
        rst = 1'b0;
        nd = 0; nw = 0;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            if (writeline_done) nd++;
            if (avm_write) nw++;
        end
        tests++; if (nd !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses expected 0", nd); end
        tests++; if (nw !== 0) begin fails++; $display("FAIL midrst_no_write: got %0d cycles expected 0", nw); end
        ln = {32'h8888_0004, 32'h8888_0003, 32'h8888_0002, 32'h8888_0001};
        writeline_line = ln; writeline_address = 32'h0000_0240; exp_addr = 30'h0000_0090;
        writeline_do = 1'b1;
        observe(10, 32'h0, 5, 1'b0);
        tests++; if (obs_start_t[0] !== 1) begin fails++; $display("FAIL midrst_fresh_start: got %0d expected 1", obs_start_t[0]); end
        tests++; if (obs_acc !== 4) begin fails++; $display("FAIL midrst_fresh_accepts: got %0d expected 4", obs_acc); end
        tests++; if (obs_done_t[0] !== 5) begin fails++; $display("FAIL midrst_fresh_done: got %0d expected 5", obs_done_t[0]); end
        tests++; if (obs_bad !== 0) begin fails++; $display("FAIL midrst_fresh_attr: got %0d bad cycles expected 0", obs_bad); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs_beat[k] !== ln[32*k +: 32]) begin
                fails++; $display("FAIL midrst_fresh_beat%0d: got %08h expected %08h", k, obs_beat[k], ln[32*k +: 32]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_stall();
        test_stalls();
        test_guard();
        test_churn();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
